// File: rtl/shift_seq_ctrl_pkg.sv
// ============================================================================
// Module   : shift_seq_ctrl_pkg
// Purpose  : Shared definitions for the serial shift frame sequencer:
//            FSM state encoding and default frame parameters reused by the
//            serial shift blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq_ctrl_pkg;

  // Sequencer states. Encodings are fixed so other shift blocks can decode
  // a sequencer state word consistently.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Default frame geometry.
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_GAP       = 1;
  localparam bit DEF_MSB_FIRST = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_reg_core.sv
// ============================================================================
// Module   : shift_reg_core
// Purpose  : Parallel-load / serial-shift register usable as either a
//            parallel-in serial-out (tx) or serial-in parallel-out (rx) path.
// Ports    : clk     - clock, rising edge
//            rst     - asynchronous active-high reset, clears the register
//            i_load  - load i_pin (has priority over i_en)
//            i_en    - shift one position
//            i_pin   - parallel load value
//            i_sin   - serial input, enters at the tail of the register
//            o_sout  - serial output, current head bit
//            o_pout  - parallel view of the register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_pin,
  input  logic             i_sin,
  output logic             o_sout,
  output logic [WIDTH-1:0] o_pout
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  // MSB-first: head is bit WIDTH-1, new bits enter at bit 0, so after
  // WIDTH shifts the first serial-in bit sits at bit WIDTH-1.
  // LSB-first mirrors this.
  if (MSB_FIRST) begin : g_msb_first
    assign w_shifted = {r_q[WIDTH-2:0], i_sin};
    assign o_sout    = r_q[WIDTH-1];
  end else begin : g_lsb_first
    assign w_shifted = {i_sin, r_q[WIDTH-1:1]};
    assign o_sout    = r_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_pin;
    end else if (i_en) begin
      r_q <= w_shifted;
    end
  end

  assign o_pout = r_q;

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Full-duplex serial frame sequencer. Accepts a word on a
//            valid/ready handshake, shifts it out on so for WIDTH cycles
//            while capturing si into a receive word, then enforces GAP idle
//            cycles before accepting the next word.
// Ports    : CLK      - clock, rising edge
//            RES      - asynchronous active-high reset
//            tx_data  - word to send, sampled only on the accept edge
//            tx_valid - tx_data valid
//            tx_ready - idle, a word can be accepted
//            so       - serial out (flop output, 0 outside a frame)
//            frame    - high during the WIDTH shift cycles
//            si       - serial in, sampled every edge while frame=1
//            rx_data  - last complete received word
//            rx_valid - one-cycle pulse when rx_data is updated
//            busy     - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int GAP       = DEF_GAP,
  parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             so,
  output logic             frame,
  input  logic             si,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  // A zero-length gap counter is not legal; keep one bit that is never used.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] c_GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gcnt;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;

  logic             w_frame;
  logic             w_busy;
  logic             w_tx_ready;
  logic             w_accept;
  logic             w_cnt_last;
  logic             w_frame_end;
  logic             w_gap_done;
  logic [WIDTH-1:0] w_rx_pout;
  logic [WIDTH-1:0] w_rx_word;
  logic [WIDTH-1:0] w_tx_pout_unused;
  logic             w_rx_sout_unused;

  assign w_cnt_last  = (r_cnt == c_CNT_LAST);
  assign w_gap_done  = (r_gcnt == c_GAP_LAST);
  assign w_accept    = w_tx_ready & tx_valid;
  assign w_frame_end = w_frame & w_cnt_last;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_frame    = 1'b0;
    w_busy     = 1'b1;
    w_tx_ready = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy     = 1'b0;
        w_tx_ready = 1'b1;
        if (tx_valid) begin
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_frame = 1'b1;
        if (w_cnt_last) begin
          w_next = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (w_gap_done) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  // ----------------------------------------------------------- counters
  // Both counters are reloaded on entry to their state, never wrapped.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_cnt  <= '0;
      r_gcnt <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if (w_frame) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      end

      if (w_frame_end) begin
        r_gcnt <= '0;
      end else if ((r_state == ST_GAP) && !w_gap_done) begin
        r_gcnt <= r_gcnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------- datapath
  // The tx register shifts in zeros, so after the last bit it is empty and
  // so falls to 0 without extra gating; so stays a pure flop output.
  shift_reg_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_tx_sr (
    .clk    (CLK),
    .rst    (RES),
    .i_load (w_accept),
    .i_en   (w_frame),
    .i_pin  (tx_data),
    .i_sin  (1'b0),
    .o_sout (so),
    .o_pout (w_tx_pout_unused)
  );

  shift_reg_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_rx_sr (
    .clk    (CLK),
    .rst    (RES),
    .i_load (w_accept),
    .i_en   (w_frame),
    .i_pin  ({WIDTH{1'b0}}),
    .i_sin  (si),
    .o_sout (w_rx_sout_unused),
    .o_pout (w_rx_pout)
  );

  // On the last shift edge the final si bit has not reached the rx
  // register yet, so the complete word is assembled here.
  if (MSB_FIRST) begin : g_asm_msb
    assign w_rx_word = {w_rx_pout[WIDTH-2:0], si};
  end else begin : g_asm_lsb
    assign w_rx_word = {si, w_rx_pout[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_frame_end;
      if (w_frame_end) begin
        r_rx_data <= w_rx_word;
      end
    end
  end

  assign tx_ready = w_tx_ready;
  assign frame    = w_frame;
  assign busy     = w_busy;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// ============================================================================
// Module   : tb_shift_seq_ctrl
// Purpose  : Self-checking bench for shift_seq_ctrl. Two instances:
//            dut0 WIDTH=8 GAP=1 MSB-first, dut1 WIDTH=8 GAP=0 LSB-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq_ctrl;

  localparam int W = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RES;
  logic [1:0]   tx_valid;
  logic [1:0]   si;
  logic [1:0]   tx_ready;
  logic [1:0]   so;
  logic [1:0]   frame;
  logic [1:0]   rx_valid;
  logic [1:0]   busy;
  logic [W-1:0] tx_data0, tx_data1, rx_data0, rx_data1;

  int n_checks = 0;
  int n_pass   = 0;

  shift_seq_ctrl #(.WIDTH(W), .GAP(1), .MSB_FIRST(1'b1)) u_dut0 (
    .CLK(CLK), .RES(RES), .tx_data(tx_data0), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .so(so[0]), .frame(frame[0]), .si(si[0]),
    .rx_data(rx_data0), .rx_valid(rx_valid[0]), .busy(busy[0])
  );

  shift_seq_ctrl #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b0)) u_dut1 (
    .CLK(CLK), .RES(RES), .tx_data(tx_data1), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .so(so[1]), .frame(frame[1]), .si(si[1]),
    .rx_data(rx_data1), .rx_valid(rx_valid[1]), .busy(busy[1])
  );

  // ------------------------------------------------------ reference model
  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // Bit sent on the wire at time slot i of a frame carrying word w.
  function automatic logic exp_bit(input logic [W-1:0] w, input int i, input int d);
    if (d == 0) return w[W-1-i];
    return w[i];
  endfunction

  function automatic logic [W-1:0] rxd(input int d);
    return (d == 0) ? rx_data0 : rx_data1;
  endfunction

  task automatic set_txd(input int d, input logic [W-1:0] v);
    if (d == 0) tx_data0 = v;
    else        tx_data1 = v;
  endtask

  task automatic wait_ready(input int d, input string tag);
    int t = 0;
    @(negedge CLK);
    while (tx_ready[d] !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    n_checks++;
    if (tx_ready[d] !== 1'b1)
      $display("FAIL %s ready_timeout dut%0d: tx_ready=%b required 1", tag, d, tx_ready[d]);
    else n_pass++;
  endtask

  // One complete frame: loopback (si=so) or si driven from si_word.
  // With scramble, tx_data/tx_valid are disturbed during SHIFT and GAP.
  task automatic run_frame(input int d, input logic [W-1:0] data, input bit loopback,
                           input logic [W-1:0] si_word, input bit scramble, input string tag);
    logic [W-1:0] exp_rx;
    int           g;
    exp_rx = loopback ? data : si_word;
    g      = gap_of(d);
    wait_ready(d, tag);
    set_txd(d, data);
    tx_valid[d] = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge CLK);
      if (scramble && i < W-1) begin
        tx_valid[d] = 1'(($urandom % 2));
        set_txd(d, W'($urandom));
      end else begin
        tx_valid[d] = 1'b0;
      end
      n_checks++;
      if (frame[d] !== 1'b1 || tx_ready[d] !== 1'b0 || busy[d] !== 1'b1)
        $display("FAIL %s shift_ctl dut%0d bit%0d: frame/ready/busy=%b%b%b required 101",
                 tag, d, i, frame[d], tx_ready[d], busy[d]);
      else n_pass++;
      n_checks++;
      if (so[d] !== exp_bit(data, i, d))
        $display("FAIL %s so dut%0d bit%0d: got %b required %b", tag, d, i, so[d], exp_bit(data, i, d));
      else n_pass++;
      si[d] = loopback ? so[d] : exp_bit(si_word, i, d);
    end
    for (int k = 0; k <= g; k++) begin
      @(negedge CLK);
      tx_valid[d] = (scramble && k < g) ? 1'b1 : 1'b0;
      n_checks++;
      if (frame[d] !== 1'b0 || so[d] !== 1'b0 || rx_valid[d] !== (k == 0) ||
          tx_ready[d] !== (k == g) || busy[d] !== (k < g))
        $display("FAIL %s post dut%0d cyc%0d: frame/so/rxv/ready/busy=%b%b%b%b%b required 00%b%b%b",
                 tag, d, k, frame[d], so[d], rx_valid[d], tx_ready[d], busy[d],
                 (k == 0), (k == g), (k < g));
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (rxd(d) !== exp_rx)
          $display("FAIL %s rx_data dut%0d: got %h required %h", tag, d, rxd(d), exp_rx);
        else n_pass++;
      end
    end
    @(negedge CLK);
    n_checks++;
    if (rx_valid[d] !== 1'b0 || frame[d] !== 1'b0 || rxd(d) !== exp_rx)
      $display("FAIL %s hold dut%0d: rxv=%b frame=%b rx=%h required 0 0 %h",
               tag, d, rx_valid[d], frame[d], rxd(d), exp_rx);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    RES = 1'b0; tx_valid = '0; si = '0; tx_data0 = '0; tx_data1 = '0;
    #1 RES = 1'b1;
    #1;
    n_checks++;
    if (tx_ready !== 2'b11 || frame !== 2'b00 || so !== 2'b00 || busy !== 2'b00 ||
        rx_valid !== 2'b00 || rx_data0 !== '0 || rx_data1 !== '0)
      $display("FAIL reset_vals: ready=%b frame=%b so=%b busy=%b rxv=%b rx0=%h rx1=%h required 11 00 00 00 00 00 00",
               tx_ready, frame, so, busy, rx_valid, rx_data0, rx_data1);
    else n_pass++;
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (tx_ready !== 2'b11 || frame !== 2'b00)
      $display("FAIL reset_release: ready=%b frame=%b required 11 00", tx_ready, frame);
    else n_pass++;
  endtask

  task automatic test_loopback_msb();
    run_frame(0, 8'hA5, 1'b1, 8'h00, 1'b0, "a5_loop");
  endtask

  task automatic test_lsb_si_high();
    run_frame(1, 8'h3C, 1'b0, 8'hFF, 1'b0, "3c_si1");
  endtask

  // tx_valid held across two words; frame gap must be GAP+1 low cycles.
  task automatic test_back_to_back(input int d, input logic [W-1:0] w0, input logic [W-1:0] w1);
    int g, n, hi;
    logic ef, es, ev;
    g  = gap_of(d);
    n  = 2*W + g + 2;
    hi = 0;
    wait_ready(d, "b2b");
    set_txd(d, w0);
    tx_valid[d] = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      ef = (c <= W) || (c >= W+g+2 && c <= 2*W+g+1);
      es = (c <= W) ? exp_bit(w0, c-1, d) : (ef ? exp_bit(w1, c-W-g-2, d) : 1'b0);
      ev = (c == W+1) || (c == n);
      n_checks++;
      if (frame[d] !== ef || so[d] !== es || rx_valid[d] !== ev)
        $display("FAIL b2b dut%0d cyc%0d: frame/so/rxv=%b%b%b required %b%b%b",
                 d, c, frame[d], so[d], rx_valid[d], ef, es, ev);
      else n_pass++;
      if (ev) begin
        n_checks++;
        if (rxd(d) !== ((c == W+1) ? w0 : w1))
          $display("FAIL b2b rx_data dut%0d cyc%0d: got %h required %h",
                   d, c, rxd(d), ((c == W+1) ? w0 : w1));
        else n_pass++;
      end
      if (frame[d] === 1'b1) hi++;
      si[d] = so[d];
      if (c == 1) set_txd(d, w1);
      if (c == W+g+2) tx_valid[d] = 1'b0;
    end
    n_checks++;
    if (hi != 2*W)
      $display("FAIL b2b frame_count dut%0d: got %0d required %0d", d, hi, 2*W);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0;
    run_frame(0, 8'h0F, 1'b0, 8'h55, 1'b0, "pre_rst0");
    run_frame(1, 8'h99, 1'b0, 8'hA6, 1'b0, "pre_rst1");
    wait_ready(0, "mid_rst");
    tx_data0    = 8'hF0;
    tx_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tx_valid[0] = 1'b0;
      n_checks++;
      if (so[0] !== exp_bit(8'hF0, i, 0))
        $display("FAIL mid_rst so bit%0d: got %b required %b", i, so[0], exp_bit(8'hF0, i, 0));
      else n_pass++;
      si[0] = so[0];
    end
    #2 RES = 1'b1;
    #1;
    n_checks++;
    if (frame !== 2'b00 || so !== 2'b00 || rx_valid !== 2'b00 || busy !== 2'b00 ||
        tx_ready !== 2'b11 || rx_data0 !== '0 || rx_data1 !== '0)
      $display("FAIL mid_rst async: frame=%b so=%b rxv=%b busy=%b ready=%b rx0=%h rx1=%h required 00 00 00 00 11 00 00",
               frame, so, rx_valid, busy, tx_ready, rx_data0, rx_data1);
    else n_pass++;
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    for (int i = 0; i < W+2; i++) begin
      @(negedge CLK);
      if (rx_valid[0] !== 1'b0 || frame[0] !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0 || rx_data0 !== '0)
      $display("FAIL mid_rst quiet: active_cycles=%0d rx=%h required 0 00", seen, rx_data0);
    else n_pass++;
    run_frame(0, 8'hF0, 1'b1, 8'h00, 1'b0, "post_rst");
  endtask

  task automatic test_scramble();
    run_frame(0, 8'h5A, 1'b1, 8'h00, 1'b1, "scr0");
    run_frame(1, 8'hC3, 1'b1, 8'h00, 1'b1, "scr1");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_frame(int'($urandom % 2), W'($urandom), 1'($urandom % 2),
                W'($urandom), 1'($urandom % 2), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_loopback_msb();
    test_lsb_si_high();
    test_back_to_back(0, 8'h12, 8'h34);
    test_back_to_back(1, 8'h12, 8'h34);
    test_reset_mid_frame();
    test_scramble();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
